key_event_module: RTL and testbench

Parametrised multi-key front end for the digital clock's push buttons. Each raw, active-low, bouncing key input is synchronised and debounced independently. The block then produces a stable level plus one-cycle press, release, long-press and auto-repeat events. It sits between the board buttons and the time-setting control logic, and carries the full event set so that control logic never filters keys itself.

---
 rtl/key_event_module.sv | 152 +++++++++++++++
 tb/tb_key_event_module.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_module.sv
// Multi-key push-button front end: sync, debounce, press/release/long/repeat events.
// Latency: events and key_level update DEB_CYCLES+2 clocks after a stable key change is first sampled.
// No backpressure: every event is a one-clock pulse that downstream logic must take when it appears.
module key_event_module #(
  parameter int KEY_NUM     = 4,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000,
  parameter int REP_CYCLES  = 10_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_out,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  localparam int DW       = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REP_CYCLES) ? LONG_CYCLES : REP_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYCLES - 1);

  typedef enum logic [1:0] {REL, PRS, LNG} state_t;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    logic          sync1_q, sync2_q;
    logic [DW-1:0] deb_q, deb_d;
    logic          acc_q, acc_d;        // accepted level, active-high
    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          lvl_q, lvl_d;
    logic          out_q, out_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          press_evt, release_evt;

    // Two-flop synchroniser; reset to released so a held key re-reports after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= key[i];
        sync2_q <= sync1_q;
      end
    end

    // Debounce: count consecutive clocks the synced key disagrees with the accepted level.
    always_comb begin
      deb_d = '0;
      acc_d = acc_q;
      if (~sync2_q != acc_q) begin
        if (deb_q == DEB_LAST) begin
          acc_d = ~acc_q;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
    end

    // Accepted-level change is turned into an FSM event one clock later, aligned with key_level.
    assign press_evt   = acc_q & ~lvl_q;
    assign release_evt = ~acc_q & lvl_q;

    // Hold FSM next state and event pulses; release always wins over long/repeat.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      lvl_d   = acc_q;
      out_d   = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      case (state_q)
        REL: begin
          hold_d = '0;
          if (press_evt) begin
            state_d = PRS;
            out_d   = 1'b1;
          end
        end
        PRS: begin
          if (release_evt) begin
            state_d = REL;
            rel_d   = 1'b1;
            hold_d  = '0;
          end else if (hold_q == LONG_LAST) begin
            state_d = LNG;
            long_d  = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        LNG: begin
          if (release_evt) begin
            state_d = REL;
            rel_d   = 1'b1;
            hold_d  = '0;
          end else if (hold_q == REP_LAST) begin
            rep_d  = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: begin
          state_d = REL;
          hold_d  = '0;
        end
      endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_q   <= '0;
        acc_q   <= 1'b0;
        state_q <= REL;
        hold_q  <= '0;
        lvl_q   <= 1'b0;
        out_q   <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        deb_q   <= deb_d;
        acc_q   <= acc_d;
        state_q <= state_d;
        hold_q  <= hold_d;
        lvl_q   <= lvl_d;
        out_q   <= out_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
      end
    end

    assign key_level[i]   = lvl_q;
    assign key_out[i]     = out_q;
    assign key_release[i] = rel_q;
    assign key_long[i]    = long_q;
    assign key_repeat[i]  = rep_q;
  end

endmodule

// File: tb/tb_key_event_module.sv
// Bench for key_event_module: directed test-plan phases plus random key waveforms.
// Expected events are derived from key run lengths and hold times, queued by cycle.
// A negedge monitor pops due events and compares the full output bundle every clock.
module tb_key_event_module;

  localparam int KN   = 4;
  localparam int DEB  = 25;
  localparam int LONG = 100;
  localparam int REP  = 40;

  localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

  typedef struct {
    int cyc;
    int k;
    int kind;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [KN-1:0] key_drv;
  logic [KN-1:0] key_level, key_out, key_release, key_long, key_repeat;

  key_event_module #(
    .KEY_NUM(KN), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REP_CYCLES(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key_drv),
    .key_level(key_level), .key_out(key_out), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  always #10 clk = ~clk;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model state, per key
  logic m_last[KN];
  int   m_run[KN];
  logic m_acc[KN];
  logic m_held[KN];
  int   m_press_t[KN];
  int   m_rel_t[KN];

  task automatic push(input int c, input int k, input int kind);
    ev_t e;
    e.cyc = c; e.k = k; e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Model: a level is accepted once the raw key has held a new value for DEB samples;
  // the resulting event appears 3 clocks after the DEB-th sample. Long/repeat follow by arithmetic.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    for (int k = 0; k < KN; k++) begin
      if (!rst_n) begin
        m_last[k] = 1'b1; m_run[k] = 0; m_acc[k] = 1'b0;
        m_held[k] = 1'b0; m_press_t[k] = 0; m_rel_t[k] = -1;
      end else begin
        if (key_drv[k] == m_last[k]) m_run[k] = m_run[k] + 1;
        else begin m_run[k] = 1; m_last[k] = key_drv[k]; end
        if ((!m_last[k]) != m_acc[k] && m_run[k] == DEB) begin
          m_acc[k] = !m_last[k];
          if (m_acc[k]) begin
            push(cyc + 3, k, K_PRESS);
            m_press_t[k] = cyc + 3; m_rel_t[k] = -1; m_held[k] = 1'b1;
          end else begin
            push(cyc + 3, k, K_REL);
            m_rel_t[k] = cyc + 3;
          end
        end
        if (m_held[k]) begin
          if (m_rel_t[k] != -1 && cyc >= m_rel_t[k]) m_held[k] = 1'b0;
          else begin
            int d;
            d = cyc - m_press_t[k];
            if (d == LONG) push(cyc, k, K_LONG);
            else if (d > LONG && (d - LONG) % REP == 0) push(cyc, k, K_REP);
          end
        end
      end
    end
  end

  logic [KN-1:0] exp_lvl = '0;

  // Monitor: pop every event due this cycle and compare the whole output bundle.
  initial forever begin
    logic [KN-1:0] e_out, e_rel, e_long, e_rep;
    @(negedge clk);
    e_out = '0; e_rel = '0; e_long = '0; e_rep = '0;
    if (!rst_n) begin
      exp_q.delete();
      exp_lvl = '0;
    end else begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= cyc) begin
          case (exp_q[i].kind)
            K_PRESS: begin e_out[exp_q[i].k] = 1'b1; exp_lvl[exp_q[i].k] = 1'b1; end
            K_REL:   begin e_rel[exp_q[i].k] = 1'b1; exp_lvl[exp_q[i].k] = 1'b0; end
            K_LONG:  e_long[exp_q[i].k] = 1'b1;
            default: e_rep[exp_q[i].k]  = 1'b1;
          endcase
          exp_q.delete(i);
        end
      end
    end
    n_cmp = n_cmp + 1;
    if ({key_level, key_out, key_release, key_long, key_repeat} !==
        {exp_lvl, e_out, e_rel, e_long, e_rep}) begin
      n_bad = n_bad + 1;
      $display("FAIL outputs cyc=%0d rst_n=%b got lvl=%b out=%b rel=%b long=%b rep=%b expected lvl=%b out=%b rel=%b long=%b rep=%b",
               cyc, rst_n, key_level, key_out, key_release, key_long, key_repeat,
               exp_lvl, e_out, e_rel, e_long, e_rep);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  int rem[KN];

  initial begin
    rst_n   = 1'b0;
    key_drv = 4'b1111;
    #123;
    rst_n = 1'b1;
    tick(25);

    // Clean press/release on key 2 (50 clocks low)
    key_drv = 4'b1011;
    tick(50);
    key_drv = 4'b1111;
    tick(60);

    // Bounce on key 1: period 10 clocks for 200 clocks
    for (int i = 0; i < 40; i++) begin
      key_drv[1] = ~key_drv[1];
      tick(5);
    end
    tick(40);

    // Long press with repeats on key 0, released before the fifth repeat
    key_drv[0] = 1'b0;
    tick(DEB + 2 + 270);
    key_drv[0] = 1'b1;
    tick(60);

    // Two keys pressed on the same edge
    key_drv = 4'b0101;
    tick(40);
    key_drv = 4'b1111;
    tick(60);

    // Reset while key 3 is long-held, still held across reset release
    key_drv[3] = 1'b0;
    tick(DEB + 2 + LONG + 50);
    rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(60);
    key_drv[3] = 1'b1;
    tick(60);

    // Random mix of bounces and holds on all keys
    for (int k = 0; k < KN; k++) rem[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < KN; k++) begin
        if (rem[k] == 0) begin
          key_drv[k] = ~key_drv[k];
          rem[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12))
                                               : int'($urandom_range(20, 200));
        end else begin
          rem[k] = rem[k] - 1;
        end
      end
      tick(1);
    end
    key_drv = 4'b1111;
    tick(200);

    // Every queued expectation must have been consumed
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
